// File: rtl/demux_1to2_buf.sv
// demux_1to2_buf: steers one valid/ready input stream into one of two
// independent 2-entry (head + skid) output buffers selected by select_i.
// Optional per-channel accepted-word counters are built when the macro
// DEMUX_STATS_EN is defined; otherwise count0_o/count1_o are tied to zero.
module demux_1to2_buf #(
  parameter int unsigned size = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [size-1:0]   data_i,
  input  logic              select_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [size-1:0]   data0_o,
  output logic              valid0_o,
  input  logic              ready0_i,
  output logic [size-1:0]   data1_o,
  output logic              valid1_o,
  input  logic              ready1_i,
  output logic [15:0]       count0_o,
  output logic [15:0]       count1_o
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e            state_q [NCH];
  state_e            state_d [NCH];
  logic [size-1:0]   head_q  [NCH];
  logic [size-1:0]   head_d  [NCH];
  logic [size-1:0]   skid_q  [NCH];
  logic [size-1:0]   skid_d  [NCH];
  logic [NCH-1:0]    valid_q;
  logic [NCH-1:0]    valid_d;

  logic [NCH-1:0]    full_c;
  logic [NCH-1:0]    push_c;
  logic [NCH-1:0]    pop_c;
  logic [NCH-1:0]    out_ready_c;
  logic              in_xfer_c;

  // Handshake decode: full flags come straight from registered state.
  always_comb begin
    out_ready_c = {ready1_i, ready0_i};
    for (int x = 0; x < NCH; x++) begin
      full_c[x] = (state_q[x] == ST_TWO);
      pop_c[x]  = valid_q[x] & out_ready_c[x];
    end
    ready_o   = select_i ? ~full_c[1] : ~full_c[0];
    in_xfer_c = valid_i & ready_o;
    push_c[0] = in_xfer_c & ~select_i;
    push_c[1] = in_xfer_c &  select_i;
  end

  // Per-channel next-state: EMPTY -> ONE -> TWO buffer control.
  always_comb begin
    for (int x = 0; x < NCH; x++) begin
      state_d[x] = state_q[x];
      head_d[x]  = head_q[x];
      skid_d[x]  = skid_q[x];
      valid_d[x] = valid_q[x];
      case (state_q[x])
        ST_EMPTY: begin
          if (push_c[x]) begin
            head_d[x]  = data_i;
            state_d[x] = ST_ONE;
            valid_d[x] = 1'b1;
          end
        end
        ST_ONE: begin
          if (push_c[x] && pop_c[x]) begin
            head_d[x] = data_i;
          end else if (push_c[x]) begin
            skid_d[x]  = data_i;
            state_d[x] = ST_TWO;
          end else if (pop_c[x]) begin
            state_d[x] = ST_EMPTY;
            valid_d[x] = 1'b0;
          end
        end
        ST_TWO: begin
          // Pushes are refused here because ready_o is low for this channel.
          if (pop_c[x]) begin
            head_d[x]  = skid_q[x];
            state_d[x] = ST_ONE;
          end
        end
        default: begin
          state_d[x] = ST_EMPTY;
          valid_d[x] = 1'b0;
        end
      endcase
    end
  end

  // Buffer state and data registers; reset clears everything immediately.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int x = 0; x < NCH; x++) begin
        state_q[x] <= ST_EMPTY;
        head_q[x]  <= '0;
        skid_q[x]  <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int x = 0; x < NCH; x++) begin
        state_q[x] <= state_d[x];
        head_q[x]  <= head_d[x];
        skid_q[x]  <= skid_d[x];
      end
      valid_q <= valid_d;
    end
  end

  assign data0_o  = head_q[0];
  assign data1_o  = head_q[1];
  assign valid0_o = valid_q[0];
  assign valid1_o = valid_q[1];

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  // Saturating accepted-word counters, one per channel.
  always_comb begin
    for (int x = 0; x < NCH; x++) begin
      cnt_d[x] = cnt_q[x];
      if (push_c[x] && (cnt_q[x] != {CNT_W{1'b1}})) begin
        cnt_d[x] = cnt_q[x] + CNT_W'(1);
      end
    end
  end

  // Counter registers clear only on reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int x = 0; x < NCH; x++) begin
        cnt_q[x] <= '0;
      end
    end else begin
      for (int x = 0; x < NCH; x++) begin
        cnt_q[x] <= cnt_d[x];
      end
    end
  end

  assign count0_o = cnt_q[0];
  assign count1_o = cnt_q[1];
`else
  assign count0_o = CNT_W'(0);
  assign count1_o = CNT_W'(0);
`endif

endmodule

// File: tb/tb_demux_1to2_buf.sv
// Directed self-checking bench for demux_1to2_buf.
module tb_demux_1to2_buf;

`ifdef DEMUX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i;
  logic        rst_i;
  logic [31:0] data_i;
  logic        select_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data0_o;
  logic        valid0_o;
  logic        ready0_i;
  logic [31:0] data1_o;
  logic        valid1_o;
  logic        ready1_i;
  logic [15:0] count0_o;
  logic [15:0] count1_o;

  int n_cmp;
  int n_bad;

  demux_1to2_buf #(.size(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .data_i   (data_i),
    .select_i (select_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .data0_o  (data0_o),
    .valid0_o (valid0_o),
    .ready0_i (ready0_i),
    .data1_o  (data1_o),
    .valid1_o (valid1_o),
    .ready1_i (ready1_i),
    .count0_o (count0_o),
    .count1_o (count1_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] cexp(input int n);
    return STATS ? 32'(n) : 32'h0;
  endfunction

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_i    = 1'b1;
    data_i   = '0;
    select_i = 1'b0;
    valid_i  = 1'b0;
    ready0_i = 1'b0;
    ready1_i = 1'b0;
    #1 rst_i = 1'b0;
    #1;

    // Reset state
    check("rst_valid0", 32'(valid0_o), 32'h0);
    check("rst_valid1", 32'(valid1_o), 32'h0);
    check("rst_data0", data0_o, 32'h0);
    check("rst_count0", 32'(count0_o), 32'h0);
    check("rst_count1", 32'(count1_o), 32'h0);
    check("rst_ready_sel0", 32'(ready_o), 32'h1);
    select_i = 1'b1;
    #1;
    check("rst_ready_sel1", 32'(ready_o), 32'h1);
    tick();
    tick();
    rst_i = 1'b1;
    tick();
    check("idle_valid0", 32'(valid0_o), 32'h0);

    // Steering
    ready0_i = 1'b1;
    ready1_i = 1'b1;
    valid_i  = 1'b1;
    select_i = 1'b0;
    data_i   = 32'hAAAA0001;
    tick();
    check("steer_valid0", 32'(valid0_o), 32'h1);
    check("steer_data0", data0_o, 32'hAAAA0001);
    check("steer_valid1_idle", 32'(valid1_o), 32'h0);
    select_i = 1'b1;
    data_i   = 32'hBBBB0002;
    tick();
    check("steer_valid1", 32'(valid1_o), 32'h1);
    check("steer_data1", data1_o, 32'hBBBB0002);
    check("steer_valid0_popped", 32'(valid0_o), 32'h0);
    check("steer_count0", 32'(count0_o), cexp(1));
    check("steer_count1", 32'(count1_o), cexp(1));
    valid_i = 1'b0;
    tick();
    check("steer_valid1_popped", 32'(valid1_o), 32'h0);

    // Back-pressure and isolation
    ready0_i = 1'b0;
    ready1_i = 1'b0;
    valid_i  = 1'b1;
    select_i = 1'b0;
    data_i   = 32'h10;
    #1;
    check("bp_ready_10", 32'(ready_o), 32'h1);
    tick();
    data_i = 32'h11;
    #1;
    check("bp_ready_11", 32'(ready_o), 32'h1);
    tick();
    data_i = 32'h12;
    #1;
    check("bp_ready_12", 32'(ready_o), 32'h0);
    tick();
    check("bp_head_held", data0_o, 32'h10);
    check("bp_valid0_held", 32'(valid0_o), 32'h1);
    select_i = 1'b1;
    data_i   = 32'h20;
    #1;
    check("bp_ready_ch1", 32'(ready_o), 32'h1);
    tick();
    check("bp_data1", data1_o, 32'h20);
    check("bp_valid1", 32'(valid1_o), 32'h1);
    select_i = 1'b0;
    data_i   = 32'h12;
    ready0_i = 1'b1;
    #1;
    check("bp_ready_full", 32'(ready_o), 32'h0);
    tick();
    check("bp_drain_11", data0_o, 32'h11);
    check("bp_ready_after_pop", 32'(ready_o), 32'h1);
    tick();
    check("bp_drain_12", data0_o, 32'h12);
    check("bp_valid0_12", 32'(valid0_o), 32'h1);
    valid_i = 1'b0;
    tick();
    check("bp_valid0_empty", 32'(valid0_o), 32'h0);
    check("bp_data1_kept", data1_o, 32'h20);
    ready1_i = 1'b1;
    tick();
    check("bp_valid1_empty", 32'(valid1_o), 32'h0);
    check("bp_count0", 32'(count0_o), cexp(4));
    check("bp_count1", 32'(count1_o), cexp(2));

    // Simultaneous push/pop in ONE, then a bubble-free burst
    valid_i  = 1'b1;
    select_i = 1'b0;
    data_i   = 32'h30;
    tick();
    check("pp_data_30", data0_o, 32'h30);
    data_i = 32'h31;
    tick();
    check("pp_data_31", data0_o, 32'h31);
    check("pp_valid_31", 32'(valid0_o), 32'h1);
    for (int i = 0; i < 16; i++) begin
      data_i = 32'h100 + 32'(i);
      #1;
      check($sformatf("burst_ready_%0d", i), 32'(ready_o), 32'h1);
      tick();
      check($sformatf("burst_data_%0d", i), data0_o, 32'h100 + 32'(i));
    end
    valid_i = 1'b0;
    tick();
    check("burst_valid0_empty", 32'(valid0_o), 32'h0);
    check("burst_count0", 32'(count0_o), cexp(22));

    // Reset mid-operation with both channels full
    ready0_i = 1'b0;
    ready1_i = 1'b0;
    valid_i  = 1'b1;
    select_i = 1'b0;
    data_i   = 32'h40;
    tick();
    data_i = 32'h41;
    tick();
    select_i = 1'b1;
    data_i   = 32'h50;
    tick();
    data_i = 32'h51;
    tick();
    valid_i = 1'b0;
    #1;
    check("mid_ready_full1", 32'(ready_o), 32'h0);
    select_i = 1'b0;
    #1;
    check("mid_ready_full0", 32'(ready_o), 32'h0);
    rst_i = 1'b0;
    #1;
    check("mid_rst_valid0", 32'(valid0_o), 32'h0);
    check("mid_rst_valid1", 32'(valid1_o), 32'h0);
    check("mid_rst_data0", data0_o, 32'h0);
    check("mid_rst_data1", data1_o, 32'h0);
    check("mid_rst_count0", 32'(count0_o), 32'h0);
    check("mid_rst_ready", 32'(ready_o), 32'h1);
    #1 rst_i = 1'b1;
    valid_i  = 1'b1;
    select_i = 1'b0;
    data_i   = 32'h60;
    tick();
    check("post_rst_data0", data0_o, 32'h60);
    check("post_rst_valid0", 32'(valid0_o), 32'h1);
    check("post_rst_valid1", 32'(valid1_o), 32'h0);
    valid_i  = 1'b0;
    ready0_i = 1'b1;
    tick();
    check("post_rst_popped", 32'(valid0_o), 32'h0);
    check("post_rst_count0", 32'(count0_o), cexp(1));
    check("post_rst_count1", 32'(count1_o), cexp(0));

    // Counter saturation on channel 1
`ifdef DEMUX_STATS_EN
    ready1_i = 1'b1;
    valid_i  = 1'b1;
    select_i = 1'b1;
    data_i   = 32'h77;
    for (int i = 0; i < 65540; i++) begin
      tick();
    end
    valid_i = 1'b0;
    tick();
    check("sat_count1", 32'(count1_o), 32'h0000FFFF);
    check("sat_count0", 32'(count0_o), 32'h1);
`else
    ready1_i = 1'b1;
    valid_i  = 1'b1;
    select_i = 1'b1;
    data_i   = 32'h77;
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    valid_i = 1'b0;
    tick();
    check("nostats_count1", 32'(count1_o), 32'h0);
    check("nostats_count0", 32'(count0_o), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
